retire_trace_buf: RTL and testbench
===================================

Name: retire_trace_buf

Overview:
- Synthesizable retirement trace capture, directly downstream of the ROB retire port (q_retire_rb1 / nuke_rb1).
- Records every committed uop (PC, ROBID, destination GPR, result data, nuke, ebreak) into a circular buffer.
- Freezes on a trigger: EBREAK, nuke, or a retire-stall watchdog (hang). The frozen history then drains oldest-first over a valid/ready port to the debug/JTAG side.
- Gives silicon and emulation the same last-N-retires view that the simulation dump provides.

Parameters:
- DEPTH, 16, buffer entries; power of 2, >=2.
- PC_W, 32, retired PC width.
- DATA_W, 64, result data width.
- ROBID_W, 5, ROB id width.
- TIMEOUT, 40, cycles without a retire that raise the hang trigger; >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rt_valid  in  1  one uop retires this cycle.
- rt_pc  in  PC_W  retired PC.
- rt_robid  in  ROBID_W  retired ROB id.
- rt_dst_valid  in  1  uop writes a GPR.
- rt_dst_reg  in  5  destination GPR.
- rt_data  in  DATA_W  result written.
- rt_nuke  in  1  retire caused a nuke.
- rt_ebreak  in  1  retired uop is EBREAK.
- freeze_clr  in  1  flush buffer, clear status, return to RUN.
- dout_valid  out  1  drain entry available.
- dout_ready  in  1  drain consumer accepts.
- dout_pc / dout_robid / dout_dst_valid / dout_dst_reg / dout_data / dout_nuke / dout_ebreak  out  as inputs  entry at read pointer.
- frozen  out  1  buffer is in FROZEN state.
- trig_cause  out  2  0 none, 1 ebreak, 2 nuke, 3 hang.
- count  out  $clog2(DEPTH)+1  valid entries.
- overflow  out  1  sticky; an entry was overwritten in RUN.
- dropped  out  16  saturating count of retires ignored while FROZEN.

Behaviour:
- Reset values: all outputs 0; wr_ptr = rd_ptr = 0; watchdog = 0; state RUN.
- State RUN:
  - rt_valid writes the entry at wr_ptr; wr_ptr increments modulo DEPTH.
  - Not full: count+1.
  - Full: the oldest entry is overwritten; rd_ptr increments; count stays DEPTH; overflow set.
  - dout_valid = 0 in RUN.
- Triggers, evaluated only in RUN, in priority order:
  - rt_valid & rt_ebreak gives cause 1.
  - Otherwise rt_valid & rt_nuke gives cause 2.
  - Otherwise the watchdog gives cause 3.
  - The triggering uop is captured in the same cycle. frozen and trig_cause are registered and assert the next cycle.
- Watchdog:
  - Clears to 0 on reset, rt_valid, or freeze_clr.
  - Otherwise increments in RUN, saturating at TIMEOUT.
  - Hang trigger fires when watchdog == TIMEOUT-1 and there is no rt_valid that cycle, i.e. TIMEOUT consecutive idle cycles.
  - Holds its value in FROZEN.
- State FROZEN:
  - No capture. Each rt_valid increments dropped, saturating at 0xFFFF.
  - dout_valid = (count != 0). dout_* = mem[rd_ptr], combinational from registered storage.
  - A dout_valid & dout_ready handshake advances rd_ptr and decrements count.
  - At count == 0 the block stays FROZEN with dout_valid = 0. No underflow.
  - overflow and trig_cause hold.
- freeze_clr, in any state, highest priority:
  - Next cycle: state RUN, wr_ptr = rd_ptr = 0, count = 0, overflow = 0, trig_cause = 0, dropped = 0, watchdog = 0.
  - Any same-cycle dout handshake is discarded.
  - A same-cycle rt_valid is captured after the flush: count = 1, entry at index 0. Trigger evaluation applies to that uop.
- Reset mid-drain or mid-capture: everything returns to the reset values next cycle; buffer contents are don't-care.
- Data path: storage is a flop array of DEPTH entries; no storage reset is needed because count gates visibility.

Test Plan:
- Capture then EBREAK: reset, retire 5 uops with PC 0x100, 0x104 … 0x110, the last with rt_ebreak.
  - Next cycle: frozen = 1, trig_cause = 1, count = 5.
  - Drain with dout_ready = 1: PCs 0x100…0x110 appear in order on consecutive cycles; then dout_valid = 0, count = 0.
- Wrap/overflow: DEPTH = 16, retire 20 uops with PC = i×4, then one nuke retire.
  - overflow = 1, trig_cause = 2, count = 16.
  - Drain yields PC 0x14 through 0x50 (i = 5…20).
- Hang: retire 1 uop, then hold rt_valid = 0.
  - frozen rises exactly TIMEOUT + 1 = 41 cycles after the retire cycle, with trig_cause = 3 and count = 1.
  - Also: a retire at idle cycle 39 restarts the count and no hang occurs.
- Frozen drop and backpressure: while frozen with count = 3, drive rt_valid for 4 cycles and toggle dout_ready 1,0,1,0,1.
  - dropped = 4.
  - Exactly 3 entries are delivered, with no duplicate or skip under stall.
- freeze_clr races: while frozen, assert freeze_clr with dout_ready = 1 and rt_valid = 1 (PC 0x200, no ebreak/nuke).
  - Next cycle: frozen = 0, count = 1, overflow = 0, dropped = 0, trig_cause = 0.
  - A later ebreak freezes, and the drain shows 0x200 first.
- Reset mid-drain: frozen with count = 8, drain 3, then assert reset.
  - Next cycle: all outputs 0, state RUN.
  - A new retire gives count = 1.

Source files
------------

// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: records committed uops into a circular history and
// freezes on EBREAK, nuke or a retire-stall watchdog so the history can be drained oldest-first.
module retire_trace_buf #(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 32,
    parameter int DATA_W  = 64,
    parameter int ROBID_W = 5,
    parameter int TIMEOUT = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rt_valid,
    input  logic [PC_W-1:0]            rt_pc,
    input  logic [ROBID_W-1:0]         rt_robid,
    input  logic                       rt_dst_valid,
    input  logic [4:0]                 rt_dst_reg,
    input  logic [DATA_W-1:0]          rt_data,
    input  logic                       rt_nuke,
    input  logic                       rt_ebreak,
    input  logic                       freeze_clr,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [PC_W-1:0]            dout_pc,
    output logic [ROBID_W-1:0]         dout_robid,
    output logic                       dout_dst_valid,
    output logic [4:0]                 dout_dst_reg,
    output logic [DATA_W-1:0]          dout_data,
    output logic                       dout_nuke,
    output logic                       dout_ebreak,
    output logic                       frozen,
    output logic [1:0]                 trig_cause,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN,
        FROZEN
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [ROBID_W-1:0] robid;
        logic               dst_valid;
        logic [4:0]         dst_reg;
        logic [DATA_W-1:0]  data;
        logic               nuke;
        logic               ebreak;
    } entry_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [1:0]         cause_q, cause_d;
    logic [15:0]        dropped_q, dropped_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic [1:0]         uop_cause;

    entry_t mem [DEPTH];
    entry_t wr_entry;
    entry_t rd_entry;

    assign wr_entry = '{pc: rt_pc, robid: rt_robid, dst_valid: rt_dst_valid,
                        dst_reg: rt_dst_reg, data: rt_data, nuke: rt_nuke,
                        ebreak: rt_ebreak};

    // EBREAK outranks nuke when both flag the same retiring uop
    assign uop_cause = !rt_valid ? 2'd0 :
                       rt_ebreak ? 2'd1 :
                       rt_nuke   ? 2'd2 : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cause_q    <= 2'd0;
            dropped_q  <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cause_q    <= cause_d;
            dropped_q  <= dropped_d;
            wd_q       <= wd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cause_d    = cause_q;
        dropped_d  = dropped_q;
        wd_d       = wd_q;
        wr_en      = 1'b0;
        wr_idx     = wr_ptr_q;

        if (freeze_clr) begin
            // Flush first; a uop retiring in the same cycle becomes entry 0
            state_d    = RUN;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            cause_d    = 2'd0;
            dropped_d  = '0;
            wd_d       = '0;
            if (rt_valid) begin
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_ptr_d = PTR_W'(1);
                count_d  = CNT_W'(1);
                if (uop_cause != 2'd0) begin
                    state_d = FROZEN;
                    cause_d = uop_cause;
                end
            end
        end else if (state_q == RUN) begin
            if (rt_valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                wd_d     = '0;
                if (count_q == CNT_W'(DEPTH)) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
                if (uop_cause != 2'd0) begin
                    state_d = FROZEN;
                    cause_d = uop_cause;
                end
            end else begin
                if (wd_q != WD_W'(TIMEOUT))
                    wd_d = wd_q + 1'b1;
                if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = FROZEN;
                    cause_d = 2'd3;
                end
            end
        end else begin
            if (rt_valid && dropped_q != 16'hFFFF)
                dropped_d = dropped_q + 1'b1;
            if (dout_valid && dout_ready) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; count alone decides which entries are visible
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_entry;
    end

    assign rd_entry       = mem[rd_ptr_q];
    assign frozen         = (state_q == FROZEN);
    assign dout_valid     = frozen && (count_q != '0);
    assign dout_pc        = rd_entry.pc;
    assign dout_robid     = rd_entry.robid;
    assign dout_dst_valid = rd_entry.dst_valid;
    assign dout_dst_reg   = rd_entry.dst_reg;
    assign dout_data      = rd_entry.data;
    assign dout_nuke      = rd_entry.nuke;
    assign dout_ebreak    = rd_entry.ebreak;
    assign trig_cause     = cause_q;
    assign count          = count_q;
    assign overflow       = overflow_q;
    assign dropped        = dropped_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed self-checking bench for retire_trace_buf: capture, wrap, hang watchdog,
// frozen drops with drain backpressure, freeze_clr races and reset mid-drain.
module tb_retire_trace_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rt_valid = 1'b0;
    logic [31:0] rt_pc = '0;
    logic [4:0]  rt_robid = '0;
    logic        rt_dst_valid = 1'b0;
    logic [4:0]  rt_dst_reg = '0;
    logic [63:0] rt_data = '0;
    logic        rt_nuke = 1'b0;
    logic        rt_ebreak = 1'b0;
    logic        freeze_clr = 1'b0;
    logic        dout_ready = 1'b0;
    logic        dout_valid;
    logic [31:0] dout_pc;
    logic [4:0]  dout_robid;
    logic        dout_dst_valid;
    logic [4:0]  dout_dst_reg;
    logic [63:0] dout_data;
    logic        dout_nuke;
    logic        dout_ebreak;
    logic        frozen;
    logic [1:0]  trig_cause;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] dropped;

    int checks = 0;
    int errors = 0;

    retire_trace_buf dut (
        .clk(clk), .reset(reset),
        .rt_valid(rt_valid), .rt_pc(rt_pc), .rt_robid(rt_robid),
        .rt_dst_valid(rt_dst_valid), .rt_dst_reg(rt_dst_reg), .rt_data(rt_data),
        .rt_nuke(rt_nuke), .rt_ebreak(rt_ebreak), .freeze_clr(freeze_clr),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_pc(dout_pc), .dout_robid(dout_robid), .dout_dst_valid(dout_dst_valid),
        .dout_dst_reg(dout_dst_reg), .dout_data(dout_data), .dout_nuke(dout_nuke),
        .dout_ebreak(dout_ebreak), .frozen(frozen), .trig_cause(trig_cause),
        .count(count), .overflow(overflow), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rt_valid = 1'b0; freeze_clr = 1'b0; dout_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic set_uop(input logic [31:0] pc, input logic eb, input logic nk);
        rt_valid     = 1'b1;
        rt_pc        = pc;
        rt_robid     = pc[6:2];
        rt_dst_valid = pc[2];
        rt_dst_reg   = pc[7:3];
        rt_data      = {32'hD0D0D0D0, pc};
        rt_ebreak    = eb;
        rt_nuke      = nk;
    endtask

    task automatic retire(input logic [31:0] pc, input logic eb, input logic nk);
        set_uop(pc, eb, nk);
        step();
        rt_valid = 1'b0; rt_ebreak = 1'b0; rt_nuke = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({frozen, dout_valid, trig_cause, count, overflow, dropped} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got frozen=%0b valid=%0b cause=%0d count=%0d ovf=%0b dropped=%0d, expected all 0",
                     frozen, dout_valid, trig_cause, count, overflow, dropped);
        end
    endtask

    task automatic test_ebreak_capture();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) retire(32'h100 + 32'(i * 4), 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || count !== 5'd4 || frozen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_no_dout: got valid=%0b count=%0d frozen=%0b, expected 0/4/0", dout_valid, count, frozen);
        end
        retire(32'h110, 1'b1, 1'b0);
        checks++;
        if (frozen !== 1'b1 || trig_cause !== 2'd1 || count !== 5'd5) begin
            errors++;
            $display("[TB] FAIL ebreak_freeze: got frozen=%0b cause=%0d count=%0d, expected 1/1/5", frozen, trig_cause, count);
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_pc = 32'h100 + 32'(i * 4);
            checks++;
            if (dout_valid !== 1'b1 || dout_pc !== exp_pc || dout_data !== {32'hD0D0D0D0, exp_pc}
                || dout_robid !== exp_pc[6:2] || dout_ebreak !== (i == 4)) begin
                errors++;
                $display("[TB] FAIL ebreak_drain[%0d]: got valid=%0b pc=%0h data=%0h eb=%0b, expected 1/%0h/d0d0d0d0%08h/%0b",
                         i, dout_valid, dout_pc, dout_data, dout_ebreak, exp_pc, exp_pc, i == 4);
            end
            step();
        end
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || count !== 5'd0 || frozen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ebreak_empty: got valid=%0b count=%0d frozen=%0b, expected 0/0/1", dout_valid, count, frozen);
        end
    endtask

    task automatic test_wrap_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) retire(32'(i * 4), 1'b0, 1'b0);
        retire(32'h50, 1'b0, 1'b1);
        checks++;
        if (frozen !== 1'b1 || overflow !== 1'b1 || trig_cause !== 2'd2 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL wrap_freeze: got frozen=%0b ovf=%0b cause=%0d count=%0d, expected 1/1/2/16",
                     frozen, overflow, trig_cause, count);
        end
        dout_ready = 1'b1;
        for (int i = 5; i <= 20; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout_pc !== 32'(i * 4) || dout_nuke !== (i == 20)) begin
                errors++;
                $display("[TB] FAIL wrap_drain[%0d]: got valid=%0b pc=%0h nuke=%0b, expected 1/%0h/%0b",
                         i, dout_valid, dout_pc, dout_nuke, i * 4, i == 20);
            end
            step();
        end
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1 || trig_cause !== 2'd2) begin
            errors++;
            $display("[TB] FAIL wrap_empty: got valid=%0b count=%0d ovf=%0b cause=%0d, expected 0/0/1/2",
                     dout_valid, count, overflow, trig_cause);
        end
    endtask

    task automatic test_hang();
        int n;
        do_reset();
        retire(32'h700, 1'b0, 1'b0);
        // Sampled right after the retire edge; freezing at the 40th edge after
        // that is the 41st cycle counting the retire cycle itself
        n = 0;
        while (frozen !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (n != 40 || trig_cause !== 2'd3 || count !== 5'd1) begin
            errors++;
            $display("[TB] FAIL hang_timing: got edges=%0d cause=%0d count=%0d, expected 40/3/1", n, trig_cause, count);
        end

        do_reset();
        retire(32'h700, 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) step();
        retire(32'h704, 1'b0, 1'b0);
        checks++;
        if (frozen !== 1'b0 || count !== 5'd2) begin
            errors++;
            $display("[TB] FAIL hang_restart: got frozen=%0b count=%0d, expected 0/2", frozen, count);
        end
        for (int i = 0; i < 39; i++) step();
        checks++;
        if (frozen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hang_early: got frozen=%0b, expected 0", frozen);
        end
        step();
        checks++;
        if (frozen !== 1'b1 || trig_cause !== 2'd3 || count !== 5'd2) begin
            errors++;
            $display("[TB] FAIL hang_second: got frozen=%0b cause=%0d count=%0d, expected 1/3/2", frozen, trig_cause, count);
        end
    endtask

    task automatic test_backpressure();
        logic ready_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int delivered;
        logic bad;
        do_reset();
        retire(32'h300, 1'b0, 1'b0);
        retire(32'h304, 1'b0, 1'b0);
        retire(32'h308, 1'b1, 1'b0);
        delivered = 0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) set_uop(32'h900 + 32'(c * 4), 1'b0, 1'b0);
            else rt_valid = 1'b0;
            dout_ready = ready_pat[c];
            if (dout_valid === 1'b1 && dout_pc !== 32'h300 + 32'(delivered * 4)) bad = 1'b1;
            if (dout_valid === 1'b1 && dout_ready) delivered++;
            step();
        end
        rt_valid = 1'b0; dout_ready = 1'b0;
        checks++;
        if (delivered != 3 || bad) begin
            errors++;
            $display("[TB] FAIL bp_order: got delivered=%0d out_of_order=%0b, expected 3/0", delivered, bad);
        end
        checks++;
        if (dropped !== 16'd4 || count !== 5'd0 || dout_valid !== 1'b0 || frozen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_status: got dropped=%0d count=%0d valid=%0b frozen=%0b, expected 4/0/0/1",
                     dropped, count, dout_valid, frozen);
        end
    endtask

    task automatic test_freeze_clr_race();
        do_reset();
        for (int i = 0; i < 16; i++) retire(32'h400 + 32'(i * 4), 1'b0, 1'b0);
        retire(32'h440, 1'b1, 1'b0);
        retire(32'h444, 1'b0, 1'b0);
        checks++;
        if (frozen !== 1'b1 || overflow !== 1'b1 || dropped !== 16'd1 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL clr_setup: got frozen=%0b ovf=%0b dropped=%0d count=%0d, expected 1/1/1/16",
                     frozen, overflow, dropped, count);
        end
        freeze_clr = 1'b1;
        dout_ready = 1'b1;
        retire(32'h200, 1'b0, 1'b0);
        freeze_clr = 1'b0;
        dout_ready = 1'b0;
        checks++;
        if (frozen !== 1'b0 || count !== 5'd1 || overflow !== 1'b0 || dropped !== 16'd0 || trig_cause !== 2'd0) begin
            errors++;
            $display("[TB] FAIL clr_race: got frozen=%0b count=%0d ovf=%0b dropped=%0d cause=%0d, expected 0/1/0/0/0",
                     frozen, count, overflow, dropped, trig_cause);
        end
        retire(32'h204, 1'b1, 1'b0);
        checks++;
        if (frozen !== 1'b1 || trig_cause !== 2'd1 || count !== 5'd2 || dout_pc !== 32'h200) begin
            errors++;
            $display("[TB] FAIL clr_refreeze: got frozen=%0b cause=%0d count=%0d pc=%0h, expected 1/1/2/200",
                     frozen, trig_cause, count, dout_pc);
        end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout_pc !== 32'h204 || count !== 5'd1) begin
            errors++;
            $display("[TB] FAIL clr_drain2: got valid=%0b pc=%0h count=%0d, expected 1/204/1", dout_valid, dout_pc, count);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 7; i++) retire(32'h500 + 32'(i * 4), 1'b0, 1'b0);
        retire(32'h51C, 1'b0, 1'b1);
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        dout_ready = 1'b0;
        checks++;
        if (count !== 5'd5 || dout_pc !== 32'h50C) begin
            errors++;
            $display("[TB] FAIL mid_drain: got count=%0d pc=%0h, expected 5/50c", count, dout_pc);
        end
        reset = 1'b1;
        dout_ready = 1'b1;
        step();
        reset = 1'b0;
        dout_ready = 1'b0;
        checks++;
        if ({frozen, dout_valid, trig_cause, count, overflow, dropped} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got frozen=%0b valid=%0b cause=%0d count=%0d ovf=%0b dropped=%0d, expected all 0",
                     frozen, dout_valid, trig_cause, count, overflow, dropped);
        end
        retire(32'h600, 1'b0, 1'b0);
        checks++;
        if (count !== 5'd1 || frozen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_retire: got count=%0d frozen=%0b, expected 1/0", count, frozen);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_ebreak_capture();
        test_wrap_overflow();
        test_hang();
        test_backpressure();
        test_freeze_clr_race();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
